// File: rtl/aurora_axi_rx_demux.sv
// Aurora RX stream demux: strips a per-frame header word and routes the payload to one of ETHCOUNT channels.
// Optional `AURORA_RX_DEMUX_MAGIC_CHECK_EN additionally requires header[31:16] == 16'hA55A.
module aurora_axi_rx_demux #(
    parameter int ETHCOUNT   = 4,
    parameter int HDR_CH_LSB = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [31:0]             axis_s_tdata,
    input  logic [3:0]              axis_s_tkeep,
    input  logic                    axis_s_tvalid,
    input  logic                    axis_s_tlast,
    output logic [ETHCOUNT*32-1:0]  axis_m_tdata,
    output logic [ETHCOUNT*4-1:0]   axis_m_tkeep,
    output logic [ETHCOUNT-1:0]     axis_m_tvalid,
    output logic [ETHCOUNT-1:0]     axis_m_tlast,
    output logic [15:0]             drop_cnt,
    output logic [2:0]              cur_ch
);

    typedef enum logic [1:0] {S_HDR, S_FWD, S_DROP} state_t;

    state_t                   state_q, state_d;
    logic [2:0]               cur_ch_q, cur_ch_d;
    logic [15:0]              drop_q, drop_d;
    logic [ETHCOUNT-1:0]      tvalid_q, tvalid_d;
    logic [ETHCOUNT-1:0]      tlast_q, tlast_d;
    logic [ETHCOUNT*32-1:0]   tdata_q, tdata_d;
    logic [ETHCOUNT*4-1:0]    tkeep_q, tkeep_d;

    logic [2:0]               hdr_ch;
    logic                     hdr_ok;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign hdr_ch = axis_s_tdata[HDR_CH_LSB +: 3];

    always_comb begin
        hdr_ok = ({1'b0, hdr_ch} < 4'(ETHCOUNT));
`ifdef AURORA_RX_DEMUX_MAGIC_CHECK_EN
        hdr_ok = hdr_ok && (axis_s_tdata[31:16] == 16'hA55A);
`endif
    end

    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        drop_d   = drop_q;
        tvalid_d = '0;
        tlast_d  = '0;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        if (axis_s_tvalid) begin
            case (state_q)
                S_HDR: begin
                    // A header-only frame carries no payload, so it counts as dropped.
                    if (axis_s_tlast) begin
                        drop_d = sat_inc(drop_q);
                    end else if (hdr_ok) begin
                        cur_ch_d = hdr_ch;
                        state_d  = S_FWD;
                    end else begin
                        state_d = S_DROP;
                    end
                end
                S_FWD: begin
                    for (int n = 0; n < ETHCOUNT; n++) begin
                        if (cur_ch_q == 3'(n)) begin
                            tvalid_d[n]          = 1'b1;
                            tlast_d[n]           = axis_s_tlast;
                            tdata_d[n*32 +: 32]  = axis_s_tdata;
                            tkeep_d[n*4 +: 4]    = axis_s_tkeep;
                        end
                    end
                    if (axis_s_tlast) begin
                        state_d = S_HDR;
                    end
                end
                S_DROP: begin
                    if (axis_s_tlast) begin
                        drop_d  = sat_inc(drop_q);
                        state_d = S_HDR;
                    end
                end
                default: state_d = S_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_HDR;
            cur_ch_q <= '0;
            drop_q   <= '0;
            tvalid_q <= '0;
            tlast_q  <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
        end else begin
            state_q  <= state_d;
            cur_ch_q <= cur_ch_d;
            drop_q   <= drop_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
        end
    end

    assign axis_m_tdata  = tdata_q;
    assign axis_m_tkeep  = tkeep_q;
    assign axis_m_tvalid = tvalid_q;
    assign axis_m_tlast  = tlast_q;
    assign drop_cnt      = drop_q;
    assign cur_ch        = cur_ch_q;

endmodule

// File: tb/tb_aurora_axi_rx_demux.sv
// Bench for aurora_axi_rx_demux: directed vector table, hand sequences, and random traffic vs a frame-level model.
module tb_aurora_axi_rx_demux;

    localparam int N = 4;
    localparam logic [31:0] H = 32'hA55A0000;

    logic              clk;
    logic              rstn;
    logic [31:0]       s_tdata;
    logic [3:0]        s_tkeep;
    logic              s_tvalid;
    logic              s_tlast;
    logic [N*32-1:0]   m_tdata;
    logic [N*4-1:0]    m_tkeep;
    logic [N-1:0]      m_tvalid;
    logic [N-1:0]      m_tlast;
    logic [15:0]       drop_cnt;
    logic [2:0]        cur_ch;

    int n_total = 0;
    int n_pass  = 0;

    aurora_axi_rx_demux #(.ETHCOUNT(N), .HDR_CH_LSB(0)) dut (
        .clk(clk), .rstn(rstn),
        .axis_s_tdata(s_tdata), .axis_s_tkeep(s_tkeep),
        .axis_s_tvalid(s_tvalid), .axis_s_tlast(s_tlast),
        .axis_m_tdata(m_tdata), .axis_m_tkeep(m_tkeep),
        .axis_m_tvalid(m_tvalid), .axis_m_tlast(m_tlast),
        .drop_cnt(drop_cnt), .cur_ch(cur_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level reference model: "expecting header" flag plus destination of the current frame (-1 = discard).
    bit          mdl_hdr;
    int          mdl_dest;
    logic [N-1:0] mdl_vld, mdl_last;
    logic [31:0] mdl_data [N];
    logic [3:0]  mdl_keep [N];
    int          mdl_drop;
    int          mdl_cur;

    function automatic void model_reset();
        mdl_hdr  = 1'b1;
        mdl_dest = -1;
        mdl_vld  = '0;
        mdl_last = '0;
        mdl_drop = 0;
        mdl_cur  = 0;
        for (int n = 0; n < N; n++) begin
            mdl_data[n] = '0;
            mdl_keep[n] = '0;
        end
    endfunction

    function automatic void model_beat(input logic [31:0] d, input logic [3:0] k, input logic v, input logic l);
        int ch;
        bit ok;
        mdl_vld  = '0;
        mdl_last = '0;
        if (!v) return;
        if (mdl_hdr) begin
            ch = int'(d[2:0]);
            ok = (ch < N);
`ifdef AURORA_RX_DEMUX_MAGIC_CHECK_EN
            ok = ok && (d[31:16] == 16'hA55A);
`endif
            if (l) begin
                mdl_drop = (mdl_drop < 65535) ? mdl_drop + 1 : 65535;
            end else begin
                mdl_hdr  = 1'b0;
                mdl_dest = ok ? ch : -1;
                if (ok) mdl_cur = ch;
            end
        end else begin
            if (mdl_dest >= 0) begin
                mdl_vld[mdl_dest]  = 1'b1;
                mdl_last[mdl_dest] = l;
                mdl_data[mdl_dest] = d;
                mdl_keep[mdl_dest] = k;
            end else if (l) begin
                mdl_drop = (mdl_drop < 65535) ? mdl_drop + 1 : 65535;
            end
            if (l) mdl_hdr = 1'b1;
        end
    endfunction

    function automatic logic [N*32-1:0] mdl_data_packed();
        logic [N*32-1:0] r;
        for (int n = 0; n < N; n++) r[n*32 +: 32] = mdl_data[n];
        return r;
    endfunction

    function automatic logic [N*4-1:0] mdl_keep_packed();
        logic [N*4-1:0] r;
        for (int n = 0; n < N; n++) r[n*4 +: 4] = mdl_keep[n];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_tvalid"}, 128'(m_tvalid), 128'(mdl_vld));
        chk({tag, "_tlast"},  128'(m_tlast),  128'(mdl_last));
        chk({tag, "_tdata"},  128'(m_tdata),  128'(mdl_data_packed()));
        chk({tag, "_tkeep"},  128'(m_tkeep),  128'(mdl_keep_packed()));
        chk({tag, "_drop"},   128'(drop_cnt), 128'(mdl_drop));
        chk({tag, "_cur_ch"}, 128'(cur_ch),   128'(mdl_cur));
        chk({tag, "_onehot"}, 128'($countones(m_tvalid) <= 1), 128'(1));
    endtask

    // Drive one beat, let one edge pass, sample 1 ns later and advance the model.
    task automatic step(input logic [31:0] d, input logic [3:0] k, input logic v, input logic l);
        s_tdata  = d;
        s_tkeep  = k;
        s_tvalid = v;
        s_tlast  = l;
        @(posedge clk);
        #1;
        model_beat(d, k, v, l);
    endtask

    task automatic rst_pulse();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        rstn     = 1'b0;
        #1;
        model_reset();
        chk("rst_tvalid_zero", 128'(m_tvalid), 128'(0));
        chk("rst_tlast_zero",  128'(m_tlast),  128'(0));
        chk_model("rst");
        #2;
        rstn = 1'b1;
    endtask

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        v;
        logic        l;
        logic [3:0]  ev;
        logic [3:0]  el;
        logic [15:0] edrop;
        logic [2:0]  ecur;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] d, input logic [3:0] k, input logic v, input logic l,
                                input logic [3:0] ev, input logic [3:0] el, input logic [15:0] edrop,
                                input logic [2:0] ecur);
        vec_t r;
        r.d = d; r.k = k; r.v = v; r.l = l;
        r.ev = ev; r.el = el; r.edrop = edrop; r.ecur = ecur;
        return r;
    endfunction

    vec_t vecs[$];

    initial begin
        vecs.push_back(mk(H | 32'd2,     4'hF, 1, 0, 4'b0000, 4'b0000, 16'd0, 3'd2));
        vecs.push_back(mk(32'h11111111,  4'hF, 1, 0, 4'b0100, 4'b0000, 16'd0, 3'd2));
        vecs.push_back(mk(32'h22222222,  4'h3, 1, 1, 4'b0100, 4'b0100, 16'd0, 3'd2));
        vecs.push_back(mk(H | 32'd5,     4'hF, 1, 0, 4'b0000, 4'b0000, 16'd0, 3'd2));
        vecs.push_back(mk(32'hAAAA0001,  4'hF, 1, 0, 4'b0000, 4'b0000, 16'd0, 3'd2));
        vecs.push_back(mk(32'hBBBB0002,  4'hF, 1, 0, 4'b0000, 4'b0000, 16'd0, 3'd2));
        vecs.push_back(mk(32'hCCCC0003,  4'hF, 1, 1, 4'b0000, 4'b0000, 16'd1, 3'd2));
        vecs.push_back(mk(H | 32'd0,     4'hF, 1, 0, 4'b0000, 4'b0000, 16'd1, 3'd0));
        vecs.push_back(mk(32'h0D0D0D0D,  4'hF, 1, 1, 4'b0001, 4'b0001, 16'd1, 3'd0));
        vecs.push_back(mk(H | 32'd1,     4'hF, 1, 0, 4'b0000, 4'b0000, 16'd1, 3'd1));
        vecs.push_back(mk(32'h10101010,  4'hF, 1, 0, 4'b0010, 4'b0000, 16'd1, 3'd1));
        vecs.push_back(mk(32'h20202020,  4'hF, 1, 1, 4'b0010, 4'b0010, 16'd1, 3'd1));
        vecs.push_back(mk(H | 32'd3,     4'hF, 1, 0, 4'b0000, 4'b0000, 16'd1, 3'd3));
        vecs.push_back(mk(32'h30303030,  4'hF, 1, 0, 4'b1000, 4'b0000, 16'd1, 3'd3));
        vecs.push_back(mk(32'hDEADBEEF,  4'hF, 0, 0, 4'b0000, 4'b0000, 16'd1, 3'd3));
        vecs.push_back(mk(32'hDEADBEEF,  4'hF, 0, 0, 4'b0000, 4'b0000, 16'd1, 3'd3));
        vecs.push_back(mk(32'h40404040,  4'h1, 1, 1, 4'b1000, 4'b1000, 16'd1, 3'd3));
        vecs.push_back(mk(H | 32'd2,     4'hF, 1, 1, 4'b0000, 4'b0000, 16'd2, 3'd3));
        vecs.push_back(mk(H | 32'd1,     4'hF, 1, 0, 4'b0000, 4'b0000, 16'd2, 3'd1));
        vecs.push_back(mk(32'h50505050,  4'hF, 1, 1, 4'b0010, 4'b0010, 16'd2, 3'd1));
        vecs.push_back(mk(H | 32'd3,     4'hF, 0, 1, 4'b0000, 4'b0000, 16'd2, 3'd1));
        vecs.push_back(mk(H | 32'd3,     4'hF, 1, 0, 4'b0000, 4'b0000, 16'd2, 3'd3));
        vecs.push_back(mk(32'h60606060,  4'h7, 1, 1, 4'b1000, 4'b1000, 16'd2, 3'd3));

        rstn     = 1'b1;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #2;
        rstn = 1'b0;
        #2;
        model_reset();
        chk_model("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_model("reset_held");
        #2;
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].d, vecs[i].k, vecs[i].v, vecs[i].l);
            chk($sformatf("vec%0d_tvalid", i), 128'(m_tvalid), 128'(vecs[i].ev));
            chk($sformatf("vec%0d_tlast", i),  128'(m_tlast),  128'(vecs[i].el));
            chk($sformatf("vec%0d_drop", i),   128'(drop_cnt), 128'(vecs[i].edrop));
            chk($sformatf("vec%0d_cur_ch", i), 128'(cur_ch),   128'(vecs[i].ecur));
            chk($sformatf("vec%0d_tdata", i),  128'(m_tdata),  128'(mdl_data_packed()));
            chk($sformatf("vec%0d_tkeep", i),  128'(m_tkeep),  128'(mdl_keep_packed()));
        end
        chk("held_tdata_ch2", 128'(m_tdata[2*32 +: 32]), 128'(32'h22222222));
        chk("held_tkeep_ch2", 128'(m_tkeep[2*4 +: 4]),   128'(4'h3));

        // Header with a bad magic word: discarded when the check is built in, forwarded otherwise.
        step(32'h12340001, 4'hF, 1, 0);
        step(32'h99999999, 4'hF, 1, 1);
`ifdef AURORA_RX_DEMUX_MAGIC_CHECK_EN
        chk("magic_bad_tvalid", 128'(m_tvalid), 128'(4'b0000));
        chk("magic_bad_drop",   128'(drop_cnt), 128'(16'd3));
`else
        chk("magic_ign_tvalid", 128'(m_tvalid), 128'(4'b0010));
        chk("magic_ign_drop",   128'(drop_cnt), 128'(16'd2));
`endif
        step(32'hA55A0001, 4'hF, 1, 0);
        step(32'h98989898, 4'hF, 1, 1);
        chk("magic_good_tvalid", 128'(m_tvalid), 128'(4'b0010));
        chk("magic_good_tlast",  128'(m_tlast),  128'(4'b0010));

        // Reset in the middle of a ch1 frame; the next beat must be decoded as a header.
        step(H | 32'd1, 4'hF, 1, 0);
        step(32'h77777777, 4'hF, 1, 0);
        chk("midrst_pre_tvalid", 128'(m_tvalid), 128'(4'b0010));
        chk("midrst_pre_tlast",  128'(m_tlast),  128'(4'b0000));
        rst_pulse();
        step(H | 32'd0, 4'hF, 1, 0);
        chk("midrst_hdr_tvalid", 128'(m_tvalid), 128'(4'b0000));
        chk("midrst_hdr_cur_ch", 128'(cur_ch),   128'(3'd0));
        step(32'h88888888, 4'hC, 1, 1);
        chk("midrst_pay_tvalid", 128'(m_tvalid), 128'(4'b0001));
        chk("midrst_pay_tlast",  128'(m_tlast),  128'(4'b0001));
        chk("midrst_pay_tdata",  128'(m_tdata[31:0]), 128'(32'h88888888));
        chk_model("midrst");

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] d;
            logic [3:0]  k;
            logic        v;
            logic        l;
            d = $urandom;
            if ($urandom_range(0, 4) != 0) d[31:16] = 16'hA55A;
            k = 4'($urandom);
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 3) == 0);
            if (i == 1500) rst_pulse();
            step(d, k, v, l);
            chk_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
